// File: rtl/wb_arb2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
//   state_t : arbiter FSM encoding (IDLE, XFER, ERR)
//   M0 / M1 : owner register values for master 0 (instruction) / master 1 (data)
package wb_arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arb2_pick.sv
// Combinational two-way grant decision, shared by the IDLE grant and the
// back-to-back handoff in XFER.
//   req0, req1 : live requests (cyc & stb) of master 0 / master 1
//   last       : master granted most recently
//   owner_next : master that should own the bus next (M0/M1)
// With PRIO_FIXED = 0 a tie goes to the master that was not granted last;
// with PRIO_FIXED = 1 a tie always goes to master 1.
module wb_arb2_pick
  import wb_arb2_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic owner_next
);

  always_comb begin
    owner_next = M0;
    if (req0 && req1) begin
      owner_next = (PRIO_FIXED != 0) ? M1 : ~last;
    end else if (req1) begin
      owner_next = M1;
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter: the LM32 instruction (m0) and data (m1)
// ports share one slave-side path toward the address decoder.  The owner
// keeps the bus for as long as its cyc stays high, so bursts are never split.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   mN_adr_i/dat_i/...  master N request signals (N = 0, 1)
//   mN_dat_o            slave read data, broadcast to both masters
//   mN_ack_o/err_o      ack/err, delivered to the owning master only
//   s_*_o               request signals of the owning master (0 when idle)
//   s_dat_i, s_ack_i    slave response
//   gnt_o               one-hot owner, 00 when idle
//
// Build option: define WB_ARB2_TIMEOUT_EN to add a bus watchdog that ends a
// transfer with err after TIMEOUT_CYC strobed cycles without ack.
module wb_arb2
  import wb_arb2_pkg::*;
#(
  parameter int ADR_W       = 32,
  parameter int DAT_W       = 32,
  parameter int PRIO_FIXED  = 0,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADR_W-1:0]   m0_adr_i,
  input  logic [DAT_W-1:0]   m0_dat_i,
  output logic [DAT_W-1:0]   m0_dat_o,
  input  logic [DAT_W/8-1:0] m0_sel_i,
  input  logic               m0_we_i,
  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  input  logic [ADR_W-1:0]   m1_adr_i,
  input  logic [DAT_W-1:0]   m1_dat_i,
  output logic [DAT_W-1:0]   m1_dat_o,
  input  logic [DAT_W/8-1:0] m1_sel_i,
  input  logic               m1_we_i,
  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic [ADR_W-1:0]   s_adr_o,
  output logic [DAT_W-1:0]   s_dat_o,
  output logic [DAT_W/8-1:0] s_sel_o,
  output logic               s_we_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  input  logic [DAT_W-1:0]   s_dat_i,
  input  logic               s_ack_i,
  output logic [1:0]         gnt_o
);

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   req0, req1;
  logic   own_cyc, own_stb;
  logic   pick_owner;
  logic   timeout;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign own_cyc = (owner_q == M1) ? m1_cyc_i : m0_cyc_i;
  assign own_stb = (owner_q == M1) ? m1_stb_i : m0_stb_i;

  // Read data needs no steering: only the owner sees an ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  wb_arb2_pick #(.PRIO_FIXED(PRIO_FIXED)) u_pick (
    .req0       (req0),
    .req1       (req1),
    .last       (last_q),
    .owner_next (pick_owner)
  );

`ifdef WB_ARB2_TIMEOUT_EN
  localparam int             CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wd_q;

  // An ack in the limit cycle completes the transfer instead of erroring.
  assign timeout = own_stb & ~s_ack_i & (wd_q == CNT_LIM);

  // Counts only strobed, unacked owner cycles; any break restarts it, and a
  // release/handoff (owner cyc low) clears it so the next owner starts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else if ((state_q != XFER) || !own_cyc || !own_stb || s_ack_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cyc;

  assign timeout            = 1'b0;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= M0;
      last_q  <= M1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = pick_owner;
          last_d  = pick_owner;
          state_d = XFER;
        end
      end

      XFER: begin
        s_adr_o  = (owner_q == M1) ? m1_adr_i : m0_adr_i;
        s_dat_o  = (owner_q == M1) ? m1_dat_i : m0_dat_i;
        s_sel_o  = (owner_q == M1) ? m1_sel_i : m0_sel_i;
        s_we_o   = (owner_q == M1) ? m1_we_i  : m0_we_i;
        s_cyc_o  = own_cyc;
        s_stb_o  = own_stb;
        m0_ack_o = (owner_q == M0) & s_ack_i;
        m1_ack_o = (owner_q == M1) & s_ack_i;
        gnt_o    = (owner_q == M1) ? 2'b10 : 2'b01;

        // Owner released (after a normal end or an abandon).  The owner's own
        // request is low here, so any live request belongs to the other
        // master and is handed the bus without an idle cycle.
        if (!own_cyc) begin
          if (req0 || req1) begin
            owner_d = pick_owner;
            last_d  = pick_owner;
          end else begin
            state_d = IDLE;
          end
        end else if (timeout) begin
          state_d = ERR;
        end
      end

      ERR: begin
        // Slave side is parked (cyc/stb low) while the owner sees err.
        gnt_o = (owner_q == M1) ? 2'b10 : 2'b01;
`ifdef WB_ARB2_TIMEOUT_EN
        m0_err_o = (owner_q == M0);
        m1_err_o = (owner_q == M1);
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Bench for wb_arb2: instance 0 is round-robin, instance 1 fixed priority,
// both share the same master/slave stimulus.  A transaction-level model of
// each instance predicts every output each cycle.
module tb_wb_arb2;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic [31:0] o_mdat0 [2];
  logic [31:0] o_mdat1 [2];
  logic        o_ack0  [2];
  logic        o_ack1  [2];
  logic        o_err0  [2];
  logic        o_err1  [2];
  logic [31:0] o_sadr  [2];
  logic [31:0] o_sdat  [2];
  logic [3:0]  o_ssel  [2];
  logic        o_swe   [2];
  logic        o_scyc  [2];
  logic        o_sstb  [2];
  logic [1:0]  o_gnt   [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model: who[i] = -1 when idle, else owning master; erring[i] = err cycle.
  int who    [2];
  int prev   [2];
  bit erring [2];
  int waited [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arb2 #(.ADR_W(32), .DAT_W(32), .PRIO_FIXED(g), .TIMEOUT_CYC(TO)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .m0_adr_i (m_adr[0]),
      .m0_dat_i (m_dat[0]),
      .m0_dat_o (o_mdat0[g]),
      .m0_sel_i (m_sel[0]),
      .m0_we_i  (m_we[0]),
      .m0_cyc_i (m_cyc[0]),
      .m0_stb_i (m_stb[0]),
      .m0_ack_o (o_ack0[g]),
      .m0_err_o (o_err0[g]),
      .m1_adr_i (m_adr[1]),
      .m1_dat_i (m_dat[1]),
      .m1_dat_o (o_mdat1[g]),
      .m1_sel_i (m_sel[1]),
      .m1_we_i  (m_we[1]),
      .m1_cyc_i (m_cyc[1]),
      .m1_stb_i (m_stb[1]),
      .m1_ack_o (o_ack1[g]),
      .m1_err_o (o_err1[g]),
      .s_adr_o  (o_sadr[g]),
      .s_dat_o  (o_sdat[g]),
      .s_sel_o  (o_ssel[g]),
      .s_we_o   (o_swe[g]),
      .s_cyc_o  (o_scyc[g]),
      .s_stb_o  (o_sstb[g]),
      .s_dat_i  (s_dat_i),
      .s_ack_i  (s_ack_i),
      .gnt_o    (o_gnt[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner of a contest between live requests; fixed priority for inst 1.
  function automatic int winner(input bit r0, input bit r1, input int last, input int inst);
    if (r0 && r1) return (inst == 1) ? 1 : 1 - last;
    return r1 ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      who[i]    = -1;
      prev[i]   = 1;
      erring[i] = 1'b0;
      waited[i] = 0;
    end
  endtask

  task automatic model_step();
    bit r0, r1;
    r0 = m_cyc[0] && m_stb[0];
    r1 = m_cyc[1] && m_stb[1];
    for (int i = 0; i < 2; i++) begin
      if (erring[i]) begin
        erring[i] = 1'b0;
        who[i]    = -1;
      end else if (who[i] < 0) begin
        if (r0 || r1) begin
          who[i]    = winner(r0, r1, prev[i], i);
          prev[i]   = who[i];
          waited[i] = 0;
        end
      end else if (!m_cyc[who[i]]) begin
        if (r0 || r1) begin
          who[i]    = winner(r0, r1, prev[i], i);
          prev[i]   = who[i];
          waited[i] = 0;
        end else begin
          who[i] = -1;
        end
      end
`ifdef WB_ARB2_TIMEOUT_EN
      else if (s_ack_i || !m_stb[who[i]]) begin
        waited[i] = 0;
      end else if (waited[i] + 1 >= TO) begin
        erring[i] = 1'b1;
      end else begin
        waited[i]++;
      end
`endif
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic        e_we, e_cyc, e_stb;
    logic [1:0]  e_ack, e_err, e_gnt;
    for (int i = 0; i < 2; i++) begin
      e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
      e_ack = '0; e_err = '0; e_gnt = '0;
      if (who[i] >= 0) begin
        e_gnt[who[i]] = 1'b1;
        if (erring[i]) begin
          e_err[who[i]] = 1'b1;
        end else begin
          e_adr = m_adr[who[i]];
          e_dat = m_dat[who[i]];
          e_sel = m_sel[who[i]];
          e_we  = m_we[who[i]];
          e_cyc = m_cyc[who[i]];
          e_stb = m_stb[who[i]];
          e_ack[who[i]] = s_ack_i;
        end
      end
      check($sformatf("s_adr[%0d]", i), 64'(o_sadr[i]), 64'(e_adr));
      check($sformatf("s_dat[%0d]", i), 64'(o_sdat[i]), 64'(e_dat));
      check($sformatf("ctl[%0d]", i),
            64'({o_ssel[i], o_swe[i], o_scyc[i], o_sstb[i], o_ack1[i], o_ack0[i],
                 o_err1[i], o_err0[i], o_gnt[i]}),
            64'({e_sel, e_we, e_cyc, e_stb, e_ack, e_err, e_gnt}));
      check($sformatf("m_dat[%0d]", i), {o_mdat1[i], o_mdat0[i]}, {s_dat_i, s_dat_i});
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then leave the caller 1 time unit after the edge to drive inputs.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst) model_step();
    else     model_reset();
    #1;
  endtask

  task automatic set_m(input int m, input bit cyc, input bit stb, input logic [31:0] adr);
    m_cyc[m] = cyc;
    m_stb[m] = stb;
    m_adr[m] = adr;
    m_dat[m] = $urandom;
    m_sel[m] = 4'($urandom);
    m_we[m]  = 1'($urandom);
  endtask

  initial begin
    int errs;
    int exp_errs;
    rst     = 1'b0;
    s_dat_i = '0;
    s_ack_i = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0;
      m_we[m]  = 1'b0; m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
    end
    model_reset();
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    check("idle_gnt", 64'(o_gnt[0]), 64'(2'b00));

    // Single m0 read, slave acks two cycles after stb is first seen.
    set_m(0, 1, 1, 32'h2000_0000);
    m_we[0] = 1'b0;
    cycle();
    check("m0_gnt", 64'(o_gnt[0]), 64'(2'b01));
    check("m0_adr", 64'(o_sadr[0]), 64'(32'h2000_0000));
    cycle();
    cycle();
    s_ack_i = 1'b1;
    s_dat_i = 32'hCAFE_F00D;
    #1;
    check("m0_ack", 64'(o_ack0[0]), 64'(1'b1));
    check("m1_noack", 64'(o_ack1[0]), 64'(1'b0));
    cycle();
    s_ack_i = 1'b0;
    set_m(0, 0, 0, 32'h0);
    cycle();
    cycle();

    // Tie after m0 was last served: round-robin favours m1.
    set_m(0, 1, 1, 32'h1000_0000);
    set_m(1, 1, 1, 32'h3000_0000);
    cycle();
    check("tie1_rr", 64'(o_gnt[0]), 64'(2'b10));
    check("tie1_fx", 64'(o_gnt[1]), 64'(2'b10));
    set_m(0, 0, 0, 32'h0);
    set_m(1, 0, 0, 32'h0);
    cycle();
    set_m(0, 1, 1, 32'h1000_0004);
    set_m(1, 1, 1, 32'h3000_0004);
    cycle();
    check("tie2_rr", 64'(o_gnt[0]), 64'(2'b01));
    check("tie2_fx", 64'(o_gnt[1]), 64'(2'b10));
    s_ack_i = 1'b1;
    cycle();
    s_ack_i = 1'b0;
    set_m(0, 0, 0, 32'h0);
    cycle();
    check("handoff_rr", 64'(o_gnt[0]), 64'(2'b10));
    set_m(1, 0, 0, 32'h0);
    cycle();
    cycle();

    // m1 burst of 4 beats while m0 waits.
    set_m(1, 1, 1, 32'h4000_0000);
    cycle();
    set_m(0, 1, 1, 32'h5000_0000);
    for (int k = 0; k < 8; k++) begin
      s_ack_i = k[0];
      m_adr[1] = 32'h4000_0000 + 32'(k * 2);
      cycle();
      check("burst_rr", 64'(o_gnt[0]), 64'(2'b10));
      check("burst_fx", 64'(o_gnt[1]), 64'(2'b10));
    end
    s_ack_i = 1'b0;
    set_m(1, 0, 0, 32'h0);
    cycle();
    check("after_burst_rr", 64'(o_gnt[0]), 64'(2'b01));
    check("after_burst_fx", 64'(o_gnt[1]), 64'(2'b01));
    // Ack and cyc drop in the same cycle: ack still reaches m0.
    s_ack_i = 1'b1;
    set_m(0, 0, 0, 32'h0);
    #1;
    check("ack_on_drop", 64'(o_ack0[0]), 64'(1'b1));
    cycle();
    s_ack_i = 1'b0;
    cycle();

    // Slave never acks m1.
    set_m(1, 1, 1, 32'h8000_0000);
    errs = 0;
    for (int k = 0; k < 22; k++) begin
      cycle();
      if (o_err1[0]) begin
        errs++;
        check("wd_scyc", 64'(o_scyc[0]), 64'(1'b0));
      end
    end
`ifdef WB_ARB2_TIMEOUT_EN
    exp_errs = 1;
`else
    exp_errs = 0;
`endif
    check("wd_err_pulses", 64'(errs), 64'(exp_errs));
    set_m(1, 0, 0, 32'h0);
    cycle();
    cycle();
    set_m(0, 1, 1, 32'h2000_0010);
    cycle();
    s_ack_i = 1'b1;
    #1;
    check("post_wd_ack", 64'(o_ack0[0]), 64'(1'b1));
    cycle();
    s_ack_i = 1'b0;
    set_m(0, 0, 0, 32'h0);
    cycle();

    // Asynchronous reset in the middle of a transfer.
    set_m(0, 1, 1, 32'h2000_0020);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_gnt", 64'({o_gnt[1], o_gnt[0]}), 64'(4'b0000));
    check("arst_cyc", 64'({o_scyc[1], o_scyc[0], o_sstb[1], o_sstb[0]}), 64'(4'b0000));
    set_m(1, 1, 1, 32'h3000_0020);
    cycle();
    rst = 1'b1;
    cycle();
    check("rst_tie_rr", 64'(o_gnt[0]), 64'(2'b01));
    check("rst_tie_fx", 64'(o_gnt[1]), 64'(2'b10));
    set_m(0, 0, 0, 32'h0);
    set_m(1, 0, 0, 32'h0);
    cycle();
    cycle();

    // Random traffic: masters come and go (including abandons), slave acks
    // at random, with occasional stretches of silence from the slave.
    for (int n = 0; n < 2500; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!m_cyc[m]) begin
          if ($urandom_range(3) == 0) set_m(m, 1, 1, $urandom);
        end else if ($urandom_range(4) == 0) begin
          set_m(m, 0, 0, 32'h0);
        end else begin
          m_stb[m] = ($urandom_range(5) != 0);
        end
      end
      s_ack_i = ((n % 400) < 40) ? 1'b0 : ($urandom_range(2) == 0);
      s_dat_i = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
